pcie_up_ebuf_arb: RTL and testbench
===================================

// Module: pcie_up_ebuf_arb
// PURPOSE
//  Shares the single upload empty-buffer queue read port among NUM_CH upload DMA channels.
//  Round-robin arbitrates channel requests and issues one queue read per grant.
//  Waits out the queue's read latency, then delivers the 96-bit empty-buffer descriptor to the winning channel.
//  Sits between the empty-buffer queue (read side) and the per-channel upload DMA engines.
// PARAMETERS
//  NUM_CH   4  number of upload DMA channels (2..8)
//  RD_LAT   3  cycles from EBUF_RD_REQ pulse to valid EBUF_RD_DATA and settled EBUF_RD_RDY
//  GUARD    1  extra idle cycles after capture before EBUF_RD_RDY is sampled again
// PORTS
//  PCIE_CLK        in   1           clock
//  PCIE_RST        in   1           reset: asynchronous, active-high
//  CH_EN           in   NUM_CH      per-channel enable; disabled channels are never granted
//  CH_REQ          in   NUM_CH      level request, one bit per channel; held until matching CH_VLD
//  CH_VLD          out  NUM_CH      one-hot, 1-cycle descriptor-valid pulse
//  CH_DATA         out  96          descriptor; valid only while any CH_VLD bit is set
//  EBUF_RD_RDY     in   1           queue non-empty (registered, lags pops)
//  EBUF_RD_REQ     out  1           1-cycle queue pop pulse
//  EBUF_RD_DATA    in   96          popped descriptor, valid RD_LAT cycles after EBUF_RD_REQ
//  STAT_CLR        in   1           clear the grant counters (feature only)
//  CH_GNT_CNT      out  NUM_CH*32   per-channel delivered-descriptor counters, channel i at [32i+31:32i]
// BEHAVIOUR
//  Reset values: CH_VLD=0, CH_DATA=0, EBUF_RD_REQ=0, CH_GNT_CNT=0, FSM=IDLE, hold register empty, RR pointer=0.
//  FSM states: IDLE, FETCH, WAIT, DELIVER, GUARD.
//  IDLE (no descriptor held): if |(CH_REQ&CH_EN) and EBUF_RD_RDY, latch the RR winner and go to FETCH.
//   - RR search starts at last winner+1 and wraps at NUM_CH-1 -> 0.
//  FETCH: assert EBUF_RD_REQ for exactly 1 cycle, load the latency counter with RD_LAT-1, go to WAIT.
//  WAIT: decrement the counter; at 0, capture EBUF_RD_DATA into the hold register and go to DELIVER.
//  DELIVER:
//   - winner still has CH_REQ&CH_EN: pulse CH_VLD[winner] for 1 cycle with CH_DATA=hold, clear hold, go to GUARD.
//   - winner dropped its request: keep the descriptor in the hold register, go to IDLE.
//  IDLE (descriptor held): re-arbitrate among active requesters; the new winner goes straight to DELIVER without a new pop.
//   - EBUF_RD_RDY is ignored while a descriptor is held; a held descriptor is never discarded except by reset.
//  GUARD: wait GUARD cycles, then go to IDLE. Pop-to-next-pop spacing is therefore >= RD_LAT+GUARD+2 cycles.
//  At most one pop is ever outstanding; EBUF_RD_REQ is never issued while EBUF_RD_RDY=0, so the queue cannot underflow.
//  CH_EN cleared mid-transaction: the pop completes; delivery follows the dropped-request rule.
//  Simultaneous requests: strict RR fairness; with all NUM_CH requesting continuously, every channel is served once per NUM_CH grants.
//  Reset mid-operation: immediate return to reset state; in-flight descriptor lost (the queue is reset by the same PCIE_RST).
// CONFIGURATION
//  Macro UP_EBUF_ARB_STAT_EN:
//   - defined: CH_GNT_CNT[i] increments on each CH_VLD[i] pulse, saturates at 0xFFFFFFFF.
//     STAT_CLR zeroes all counters; it wins over a same-cycle increment.
//   - undefined: counter logic is removed, CH_GNT_CNT is tied to 0, STAT_CLR is ignored; port list is unchanged.
// STRUCTURE
//  Package pcie_up_ebuf_pkg:
//   - EBUF_DW=96
//   - FSM state enum {IDLE,FETCH,WAIT,DELIVER,GUARD}
//   - descriptor typedef (96-bit opaque)
//   - counter width 32
//  Sub-module pcie_rr_arb: NUM_CH-wide round-robin arbiter.
//   - inputs: req vector, advance strobe; outputs: one-hot grant, index.
//   - pointer updates only on advance (asserted on a CH_VLD pulse).
//  Top level holds the FSM, latency counter, hold register, output registers and the optional counters.
// TESTING
//  1. Single channel: queue preloaded with 3 descriptors, CH_REQ[0]=1.
//     -> 3 CH_VLD[0] pulses with data in FIFO order; EBUF_RD_REQ-to-CH_VLD = RD_LAT+1 cycles.
//  2. All 4 channels requesting, queue holds 8 descriptors -> grant order 0,1,2,3,0,1,2,3.
//  3. Queue empty (EBUF_RD_RDY=0) with requests pending -> no EBUF_RD_REQ; first pop 1 cycle after RDY rises.
//  4. CH_REQ[1] drops during WAIT while CH_REQ[2]=1 -> the descriptor goes to ch2 with no extra pop.
//  5. CH_EN=4'b1010, all CH_REQ set -> only ch1 and ch3 are served, alternating.
//  6. PCIE_RST asserted in WAIT -> all outputs 0 next edge; after release, ch0 wins first.
//     With UP_EBUF_ARB_STAT_EN: counters match pulse counts; STAT_CLR -> all counters 0.

Source files
------------

// File: rtl/pcie_up_ebuf_pkg.sv
// Shared types for the upload empty-buffer arbiter: descriptor width, FSM states, counter helpers.
package pcie_up_ebuf_pkg;

  localparam int EBUF_DW = 96;
  localparam int CNT_W   = 32;

  typedef logic [EBUF_DW-1:0] ebuf_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DELIVER,
    ST_GUARD
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcie_rr_arb.sv
// Round-robin arbiter: search starts one past the last delivered channel; pointer moves only on advance.
module pcie_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [IW-1:0]     adv_idx,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = (int'(ptr_q) + i) % NUM_CH;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (adv_idx == IW'(NUM_CH - 1)) ? '0 : adv_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pcie_up_ebuf_arb.sv
// Shares the upload empty-buffer queue read port among NUM_CH DMA channels (round-robin, one pop per grant).
// Optional per-channel delivery counters are built when UP_EBUF_ARB_STAT_EN is defined.
module pcie_up_ebuf_arb
  import pcie_up_ebuf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int RD_LAT = 3,
  parameter int GUARD  = 1
) (
  input  logic                    PCIE_CLK,
  input  logic                    PCIE_RST,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH-1:0]       CH_REQ,
  output logic [NUM_CH-1:0]       CH_VLD,
  output logic [EBUF_DW-1:0]      CH_DATA,
  input  logic                    EBUF_RD_RDY,
  output logic                    EBUF_RD_REQ,
  input  logic [EBUF_DW-1:0]      EBUF_RD_DATA,
  input  logic                    STAT_CLR,
  output logic [NUM_CH*CNT_W-1:0] CH_GNT_CNT
);

  localparam int IW = $clog2(NUM_CH);
  localparam int CW = 8;

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     winner_q, winner_d;
  ebuf_desc_t        hold_q, hold_d;
  logic              held_q, held_d;
  logic [NUM_CH-1:0] ch_vld_q, ch_vld_d;
  ebuf_desc_t        ch_data_q, ch_data_d;
  logic              rd_req_q, rd_req_d;
  logic [NUM_CH-1:0] act, gnt;
  logic [IW-1:0]     gnt_idx;

  assign act = CH_REQ & CH_EN;

  pcie_rr_arb #(.NUM_CH(NUM_CH), .IW(IW)) u_rr (
    .clk     (PCIE_CLK),
    .rst     (PCIE_RST),
    .req     (act),
    .advance (|ch_vld_q),
    .adv_idx (winner_q),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
    if (PCIE_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      winner_q  <= '0;
      hold_q    <= '0;
      held_q    <= 1'b0;
      ch_vld_q  <= '0;
      ch_data_q <= '0;
      rd_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      hold_q    <= hold_d;
      held_q    <= held_d;
      ch_vld_q  <= ch_vld_d;
      ch_data_q <= ch_data_d;
      rd_req_q  <= rd_req_d;
    end
  end

  // DELIVER is the cycle the pulse is visible; the deliver/hold decision is made on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (held_q) begin
          if (|act) state_d = ST_DELIVER;
        end else if (|act && EBUF_RD_RDY) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
        cnt_d   = CW'(RD_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DELIVER;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DELIVER: begin
        if (|ch_vld_q && GUARD > 0) begin
          state_d = ST_GUARD;
          cnt_d   = CW'(GUARD - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    winner_d  = winner_q;
    hold_d    = hold_q;
    held_d    = held_q;
    ch_vld_d  = '0;
    ch_data_d = '0;
    rd_req_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (held_q) begin
          if (|act) begin
            winner_d  = gnt_idx;
            ch_vld_d  = gnt;
            ch_data_d = hold_q;
            hold_d    = '0;
            held_d    = 1'b0;
          end
        end else if (|act && EBUF_RD_RDY) begin
          winner_d = gnt_idx;
          rd_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (act[winner_q]) begin
            ch_vld_d[winner_q] = 1'b1;
            ch_data_d          = EBUF_RD_DATA;
          end else begin
            hold_d = EBUF_RD_DATA;
            held_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign CH_VLD      = ch_vld_q;
  assign CH_DATA     = ch_data_q;
  assign EBUF_RD_REQ = rd_req_q;

`ifdef UP_EBUF_ARB_STAT_EN
  logic [CNT_W-1:0] gnt_cnt_q [NUM_CH];
  logic [CNT_W-1:0] gnt_cnt_d [NUM_CH];

  // Clear takes priority over a same-cycle delivery.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (STAT_CLR)         gnt_cnt_d[i] = '0;
      else if (ch_vld_q[i]) gnt_cnt_d[i] = sat_inc(gnt_cnt_q[i]);
      else                  gnt_cnt_d[i] = gnt_cnt_q[i];
    end
  end

  always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
    if (PCIE_RST) begin
      for (int i = 0; i < NUM_CH; i++) gnt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) gnt_cnt_q[i] <= gnt_cnt_d[i];
    end
  end

  always_comb begin
    CH_GNT_CNT = '0;
    for (int i = 0; i < NUM_CH; i++) CH_GNT_CNT[i*CNT_W +: CNT_W] = gnt_cnt_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = STAT_CLR;
  assign CH_GNT_CNT      = '0;
`endif

endmodule

// File: tb/tb_pcie_up_ebuf_arb.sv
// Bench for pcie_up_ebuf_arb: queue model, transaction-level delivery model, directed scenarios.
module tb_pcie_up_ebuf_arb;

  localparam int NUM_CH = 4;
  localparam int RD_LAT = 3;
  localparam int GUARD  = 1;

  logic         PCIE_CLK = 1'b0;
  logic         PCIE_RST;
  logic [3:0]   CH_EN, CH_REQ;
  logic [3:0]   CH_VLD;
  logic [95:0]  CH_DATA;
  logic         EBUF_RD_RDY;
  logic         EBUF_RD_REQ;
  logic [95:0]  EBUF_RD_DATA;
  logic         STAT_CLR;
  logic [127:0] CH_GNT_CNT;

  always #5 PCIE_CLK = ~PCIE_CLK;

  pcie_up_ebuf_arb #(.NUM_CH(NUM_CH), .RD_LAT(RD_LAT), .GUARD(GUARD)) dut (
    .PCIE_CLK     (PCIE_CLK),
    .PCIE_RST     (PCIE_RST),
    .CH_EN        (CH_EN),
    .CH_REQ       (CH_REQ),
    .CH_VLD       (CH_VLD),
    .CH_DATA      (CH_DATA),
    .EBUF_RD_RDY  (EBUF_RD_RDY),
    .EBUF_RD_REQ  (EBUF_RD_REQ),
    .EBUF_RD_DATA (EBUF_RD_DATA),
    .STAT_CLR     (STAT_CLR),
    .CH_GNT_CNT   (CH_GNT_CNT)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [95:0] q_mem[$];
  logic [95:0] exp_q[$];
  logic [95:0] dq_data = '0;
  int data_valid_cyc = -1;
  logic rdy_lag = 1'b0;
  int pops = 0, first_pop_cyc = -1, rdy_rise_cyc = -1;
  int last_pop = -1000;
  logic prev_rdy = 1'b0;
  int ptr_m = 0;
  int log_q[$];
  logic [95:0] dlog[$];
  int cnt_m[4];
  int pulses = 0;
  bit chk_lat = 1'b1;
  logic [3:0] act_m;
  int w_m;

  localparam logic [95:0] JUNK = {3{32'hDEADBEEF}};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h01234567, 32'h5A5A0000 | 32'(i)};
  endfunction

  function automatic int rr_pick(input logic [3:0] a, input int p);
    for (int i = 0; i < NUM_CH; i++)
      if (a[(p + i) % NUM_CH]) return (p + i) % NUM_CH;
    return -1;
  endfunction

  function automatic int log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : -1;
  endfunction

  function automatic logic [95:0] dlog_at(input int i);
    return (i < dlog.size()) ? dlog[i] : JUNK;
  endfunction

  function automatic logic [31:0] log_pack(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[27:0], 4'(log_at(i))};
    return r;
  endfunction

  function automatic logic [127:0] cnt_pack();
    return {32'(cnt_m[3]), 32'(cnt_m[2]), 32'(cnt_m[1]), 32'(cnt_m[0])};
  endfunction

  // Empty-buffer queue: registered non-empty flag, data valid exactly RD_LAT cycles after a pop.
  always @(posedge PCIE_CLK) begin
    #1;
    cyc++;
    if (PCIE_RST) begin
      EBUF_RD_RDY    = 1'b0;
      rdy_lag        = 1'b0;
      data_valid_cyc = -1;
      EBUF_RD_DATA   = '0;
    end else begin
      EBUF_RD_DATA = (cyc == data_valid_cyc) ? dq_data : JUNK;
      if (!EBUF_RD_RDY && rdy_lag) rdy_rise_cyc = cyc;
      EBUF_RD_RDY = rdy_lag;
      if (EBUF_RD_REQ) begin
        if (q_mem.size() > 0) begin
          dq_data = q_mem.pop_front();
          exp_q.push_back(dq_data);
        end else begin
          dq_data = JUNK;
        end
        data_valid_cyc = cyc + RD_LAT;
        pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      rdy_lag = (q_mem.size() > 0);
    end
  end

  // Per-cycle compare against the delivery model.
  always @(negedge PCIE_CLK) begin
    if (PCIE_RST) begin
      prev_rdy = 1'b0;
    end else begin
      if (EBUF_RD_REQ) begin
        check("pop_while_rdy", prev_rdy, 1'b1);
        check("pop_spacing", (cyc - last_pop) >= (RD_LAT + GUARD + 2), 1'b1);
        last_pop = cyc;
      end
      if (CH_VLD != 4'b0) begin
        act_m = CH_REQ & CH_EN;
        w_m   = rr_pick(act_m, ptr_m);
        check("vld_onehot", $onehot(CH_VLD), 1'b1);
        check("vld_chan", CH_VLD, (w_m < 0) ? 4'b0 : 4'(1 << w_m));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL vld_data got=%0h exp=none_outstanding", CH_DATA);
        end else begin
          check("vld_data", CH_DATA, exp_q.pop_front());
        end
        if (chk_lat) check("vld_latency", cyc - last_pop, RD_LAT + 1);
        if (w_m >= 0) begin
          log_q.push_back(w_m);
          cnt_m[w_m]++;
          ptr_m = (w_m + 1) % NUM_CH;
        end
        dlog.push_back(CH_DATA);
        pulses++;
      end
      prev_rdy = EBUF_RD_RDY;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCIE_CLK);
      #2;
    end
  endtask

  task automatic apply_reset();
    PCIE_RST = 1'b1;
    CH_REQ   = '0;
    STAT_CLR = 1'b0;
    q_mem.delete();
    exp_q.delete();
    log_q.delete();
    dlog.delete();
    ptr_m = 0; last_pop = -1000; pops = 0; pulses = 0;
    first_pop_cyc = -1; rdy_rise_cyc = -1;
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    step(2);
    PCIE_RST = 1'b0;
    step(1);
  endtask

  task automatic wait_pulses(input int n, input string name);
    int b;
    b = 0;
    while (pulses < n && b < 300) begin
      step(1);
      b++;
    end
    check(name, pulses >= n, 1'b1);
  endtask

  task automatic wait_pop(input string name);
    int b;
    b = 0;
    while (pops < 1 && b < 100) begin
      step(1);
      b++;
    end
    check(name, pops >= 1, 1'b1);
  endtask

  initial begin
    PCIE_RST = 1'b1; CH_EN = '0; CH_REQ = '0; STAT_CLR = 1'b0;
    EBUF_RD_RDY = 1'b0; EBUF_RD_DATA = '0;
    step(3);
    check("rst_ch_vld", CH_VLD, 4'b0);
    check("rst_ch_data", CH_DATA, 96'b0);
    check("rst_rd_req", EBUF_RD_REQ, 1'b0);
    check("rst_gnt_cnt", CH_GNT_CNT, 128'b0);
    PCIE_RST = 1'b0;
    CH_EN = 4'hF;
    step(2);

    // Single channel, three descriptors in FIFO order.
    for (int i = 1; i <= 3; i++) q_mem.push_back(mk(i));
    CH_REQ = 4'b0001;
    wait_pulses(3, "t1_timeout");
    CH_REQ = '0;
    step(6);
    check("t1_order", log_pack(3), 32'h000);
    check("t1_count", log_q.size(), 3);
    check("t1_d0", dlog_at(0), 96'hC0DE0001_01234567_5A5A0001);
    check("t1_d2", dlog_at(2), 96'hC0DE0003_01234567_5A5A0003);
    check("t1_pops", pops, 3);

    // All four channels, eight descriptors.
    apply_reset();
    for (int i = 1; i <= 8; i++) q_mem.push_back(mk(i));
    CH_REQ = 4'hF;
    wait_pulses(8, "t2_timeout");
    CH_REQ = '0;
    step(5);
    check("t2_order", log_pack(8), 32'h01230123);
`ifdef UP_EBUF_ARB_STAT_EN
    check("t2_cnt", CH_GNT_CNT, {4{32'd2}});
`else
    check("t2_cnt", CH_GNT_CNT, 128'b0);
`endif
    STAT_CLR = 1'b1;
    step(1);
    STAT_CLR = 1'b0;
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    check("t2_cnt_clr", CH_GNT_CNT, 128'b0);

    // Empty queue holds off the pop until RDY rises.
    apply_reset();
    CH_REQ = 4'b0001;
    step(10);
    check("t3_no_pop", pops, 0);
    q_mem.push_back(mk(9));
    wait_pulses(1, "t3_timeout");
    CH_REQ = '0;
    check("t3_pop_after_rdy", first_pop_cyc - rdy_rise_cyc, 1);
    check("t3_data", dlog_at(0), 96'hC0DE0009_01234567_5A5A0009);
    step(3);

    // Winner drops during WAIT: held descriptor goes to ch2 without another pop.
    apply_reset();
    chk_lat = 1'b0;
    q_mem.push_back(mk(4));
    q_mem.push_back(mk(5));
    CH_REQ = 4'b0110;
    wait_pop("t4_pop_timeout");
    step(2);
    CH_REQ = 4'b0100;
    wait_pulses(1, "t4_timeout");
    CH_REQ = '0;
    step(5);
    check("t4_order", log_pack(1), 32'h2);
    check("t4_pops", pops, 1);
    check("t4_data", dlog_at(0), 96'hC0DE0004_01234567_5A5A0004);
    chk_lat = 1'b1;

    // Only enabled channels are served.
    apply_reset();
    CH_EN = 4'b1010;
    for (int i = 1; i <= 4; i++) q_mem.push_back(mk(i));
    CH_REQ = 4'hF;
    wait_pulses(4, "t5_timeout");
    CH_REQ = '0;
    step(5);
    check("t5_order", log_pack(4), 32'h1313);
`ifdef UP_EBUF_ARB_STAT_EN
    check("t5_cnt", CH_GNT_CNT, cnt_pack());
`else
    check("t5_cnt", CH_GNT_CNT, 128'b0);
`endif
    CH_EN = 4'hF;

    // Reset during WAIT drops everything; ch0 wins first afterwards.
    apply_reset();
    q_mem.push_back(mk(6));
    q_mem.push_back(mk(7));
    CH_REQ = 4'b0100;
    wait_pop("t6_pop_timeout");
    step(1);
    PCIE_RST = 1'b1;
    #1;
    check("t6_rst_vld", CH_VLD, 4'b0);
    check("t6_rst_data", CH_DATA, 96'b0);
    check("t6_rst_req", EBUF_RD_REQ, 1'b0);
    check("t6_rst_cnt", CH_GNT_CNT, 128'b0);
    apply_reset();
    q_mem.push_back(mk(8));
    CH_REQ = 4'hF;
    wait_pulses(1, "t6_timeout");
    CH_REQ = '0;
    step(3);
    check("t6_first", log_pack(1), 32'h0);
    check("t6_data", dlog_at(0), 96'hC0DE0008_01234567_5A5A0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
